// File: rtl/nd_pkg.sv
// Shared types for the ND index stepper family: tagger FSM states and a default-size index vector.
package nd_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} nd_tag_state_t;

   localparam int unsigned ND_BW  = 8;
   localparam int unsigned ND_DIM = 2;

   // Element i is dimension i; dimension ND_DIM-1 is innermost.
   typedef logic [ND_DIM-1:0][ND_BW-1:0] nd_idx_t;

endpackage

// File: rtl/nd_stream_tagger_adder.sv
// ND adder: advances an index vector by one step, wrapping each dimension to its begin on end-match.
// o_sel_end is one-hot: bit j set when exactly the j innermost dimensions wrapped.
module nd_stream_tagger_adder #(
   parameter int unsigned BW          = 8,
   parameter int unsigned DIM         = 2,
   parameter bit          UNIT_STRIDE = 1'b0,
   parameter bit          FROM_ZERO   = 1'b0
) (
   input  logic [DIM-1:0][BW-1:0] i_cur,
   input  logic [DIM-1:0][BW-1:0] i_beg,
   input  logic [DIM-1:0][BW-1:0] i_end,
   input  logic [DIM-1:0][BW-1:0] i_stride,
   input  logic                   i_restart,
   output logic [DIM-1:0][BW-1:0] o_nxt,
   output logic [DIM:0]           o_sel_end
);

   // carry[k]: the k innermost dimensions all wrapped
   logic [DIM:0]    carry;
   logic [BW-1:0]   step;
   logic [BW-1:0]   sum;
   logic [BW-1:0]   base;

   always_comb begin
      carry    = '0;
      carry[0] = 1'b1;
      o_nxt    = i_cur;
      step     = '0;
      sum      = '0;
      base     = '0;
      for (int k = 0; k < DIM; k++) begin
         step = UNIT_STRIDE ? BW'(1) : i_stride[DIM-1-k];
         base = FROM_ZERO ? '0 : i_beg[DIM-1-k];
         sum  = i_cur[DIM-1-k] + step;
         if (i_restart) begin
            o_nxt[DIM-1-k] = base;
         end else if (carry[k]) begin
            o_nxt[DIM-1-k] = (sum == i_end[DIM-1-k]) ? base : sum;
         end
         carry[k+1] = carry[k] & (sum == i_end[DIM-1-k]);
      end
   end

   always_comb begin
      o_sel_end = '0;
      for (int j = 0; j < DIM; j++) begin
         o_sel_end[j] = carry[j] & ~carry[j+1];
      end
      o_sel_end[DIM] = carry[DIM];
   end

endmodule

// File: rtl/nd_stream_tagger.sv
// Tags each beat of a flat stream with its ND position inside a configured box,
// plus begin/end one-hot flags; one register slot between src and dst.
module nd_stream_tagger #(
   parameter int unsigned BW  = 8,
   parameter int unsigned DIM = 2,
   parameter int unsigned DBW = 32
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_cfg_rdy,
   output logic                   o_cfg_ack,
   input  logic [DIM-1:0][BW-1:0] i_cfg_beg,
   input  logic [DIM-1:0][BW-1:0] i_cfg_end,
   input  logic [DIM-1:0][BW-1:0] i_cfg_stride,
   input  logic                   i_src_rdy,
   output logic                   o_src_ack,
   input  logic [DBW-1:0]         i_src_dat,
   output logic                   o_dst_rdy,
   input  logic                   i_dst_ack,
   output logic [DBW-1:0]         o_dst_dat,
   output logic [DIM-1:0][BW-1:0] o_dst_idx,
   output logic [DIM:0]           o_dst_sel_beg,
   output logic [DIM:0]           o_dst_sel_end,
   output logic                   o_dst_last,
   output logic                   o_done
);

   import nd_pkg::*;

   nd_tag_state_t           state;
   logic [DIM-1:0][BW-1:0]  cfg_beg;
   logic [DIM-1:0][BW-1:0]  cfg_end;
   logic [DIM-1:0][BW-1:0]  cfg_stride;
   logic [DIM-1:0][BW-1:0]  cur;
   logic [DIM-1:0][BW-1:0]  nxt;
   logic [DIM:0]            sel_end_nxt;
   logic [DIM:0]            sel_beg_next;
   logic [DIM:0]            sel_first;
   logic                    cfg_empty;
   logic                    src_fire;
   logic                    dst_fire;

   assign sel_first = {1'b1, {DIM{1'b0}}};

   always_comb begin
      cfg_empty = 1'b0;
      for (int i = 0; i < DIM; i++) begin
         if (i_cfg_beg[i] == i_cfg_end[i]) cfg_empty = 1'b1;
      end
   end

   // o_done doubles as the pending-done flag so a new box cannot start under a pulse.
   assign o_cfg_ack  = i_cfg_rdy & (state == IDLE) & ~i_rst & ~o_done;
   assign o_src_ack  = (state == RUN) & (~o_dst_rdy | i_dst_ack);
   assign src_fire   = o_src_ack & i_src_rdy;
   assign dst_fire   = o_dst_rdy & i_dst_ack;
   assign o_dst_last = o_dst_sel_end[DIM];

   nd_stream_tagger_adder #(
      .BW          (BW),
      .DIM         (DIM),
      .UNIT_STRIDE (1'b0),
      .FROM_ZERO   (1'b0)
   ) u_adder (
      .i_cur     (cur),
      .i_beg     (cfg_beg),
      .i_end     (cfg_end),
      .i_stride  (cfg_stride),
      .i_restart (1'b0),
      .o_nxt     (nxt),
      .o_sel_end (sel_end_nxt)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         o_dst_rdy <= 1'b0;
         o_done    <= 1'b0;
         cur       <= '0;
      end else begin
         o_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (o_cfg_ack) begin
                  cur <= i_cfg_beg;
                  if (cfg_empty) o_done <= 1'b1;
                  else           state  <= RUN;
               end
            end
            RUN: begin
               if (src_fire) begin
                  cur       <= nxt;
                  o_dst_rdy <= 1'b1;
                  if (sel_end_nxt[DIM]) state <= DRAIN;
               end else if (dst_fire) begin
                  o_dst_rdy <= 1'b0;
               end
            end
            DRAIN: begin
               if (dst_fire) begin
                  o_dst_rdy <= 1'b0;
                  o_done    <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (o_cfg_ack) begin
         cfg_beg      <= i_cfg_beg;
         cfg_end      <= i_cfg_end;
         cfg_stride   <= i_cfg_stride;
         sel_beg_next <= sel_first;
      end
      if (src_fire) begin
         o_dst_dat     <= i_src_dat;
         o_dst_idx     <= cur;
         o_dst_sel_beg <= sel_beg_next;
         o_dst_sel_end <= sel_end_nxt;
         sel_beg_next  <= sel_end_nxt;
      end
   end

endmodule

// File: tb/tb_nd_stream_tagger.sv
// Directed bench for nd_stream_tagger (BW=8, DIM=2): hand-computed beat tables per box.
module tb_nd_stream_tagger;

   logic            clk = 1'b0;
   logic            i_rst;
   logic            i_cfg_rdy;
   logic            o_cfg_ack;
   logic [1:0][7:0] i_cfg_beg;
   logic [1:0][7:0] i_cfg_end;
   logic [1:0][7:0] i_cfg_stride;
   logic            i_src_rdy;
   logic            o_src_ack;
   logic [31:0]     i_src_dat;
   logic            o_dst_rdy;
   logic            i_dst_ack;
   logic [31:0]     o_dst_dat;
   logic [1:0][7:0] o_dst_idx;
   logic [2:0]      o_dst_sel_beg;
   logic [2:0]      o_dst_sel_end;
   logic            o_dst_last;
   logic            o_done;

   int checks   = 0;
   int failures = 0;

   logic [7:0] e_i0 [8];
   logic [7:0] e_i1 [8];
   logic [2:0] e_sb [8];
   logic [2:0] e_se [8];

   always #5 clk = ~clk;

   nd_stream_tagger #(
      .BW  (8),
      .DIM (2),
      .DBW (32)
   ) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_cfg_rdy     (i_cfg_rdy),
      .o_cfg_ack     (o_cfg_ack),
      .i_cfg_beg     (i_cfg_beg),
      .i_cfg_end     (i_cfg_end),
      .i_cfg_stride  (i_cfg_stride),
      .i_src_rdy     (i_src_rdy),
      .o_src_ack     (o_src_ack),
      .i_src_dat     (i_src_dat),
      .o_dst_rdy     (o_dst_rdy),
      .i_dst_ack     (i_dst_ack),
      .o_dst_dat     (o_dst_dat),
      .o_dst_idx     (o_dst_idx),
      .o_dst_sel_beg (o_dst_sel_beg),
      .o_dst_sel_end (o_dst_sel_end),
      .o_dst_last    (o_dst_last),
      .o_done        (o_done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setb(input int k, input logic [7:0] i0, input logic [7:0] i1,
                       input logic [2:0] sb, input logic [2:0] se);
      e_i0[k] = i0;
      e_i1[k] = i1;
      e_sb[k] = sb;
      e_se[k] = se;
   endtask

   task automatic load_case1();
      setb(0, 0, 0, 3'b100, 3'b001);
      setb(1, 0, 1, 3'b001, 3'b001);
      setb(2, 0, 2, 3'b001, 3'b010);
      setb(3, 1, 0, 3'b010, 3'b001);
      setb(4, 1, 1, 3'b001, 3'b001);
      setb(5, 1, 2, 3'b001, 3'b100);
   endtask

   task automatic load_case2();
      setb(0, 0, 1, 3'b100, 3'b001);
      setb(1, 0, 4, 3'b001, 3'b010);
      setb(2, 2, 1, 3'b010, 3'b001);
      setb(3, 2, 4, 3'b001, 3'b100);
   endtask

   // Returns at posedge+1 just after the accepting edge.
   task automatic cfg(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] e0,
                      input logic [7:0] e1, input logic [7:0] s0, input logic [7:0] s1);
      i_cfg_beg[0] = b0;    i_cfg_beg[1] = b1;
      i_cfg_end[0] = e0;    i_cfg_end[1] = e1;
      i_cfg_stride[0] = s0; i_cfg_stride[1] = s1;
      i_cfg_rdy = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (o_cfg_ack) break;
         @(posedge clk); #1;
      end
      chk("cfg_ack", o_cfg_ack, 1);
      @(posedge clk); #1;
      i_cfg_rdy = 1'b0;
   endtask

   task automatic run_box(input string name, input int nbeats, input logic [31:0] base,
                          input bit stall);
      int got = 0, sent = 0, dones = 0, last_cyc = -10, done_cyc = 0;
      logic p_rdy = 1'b0, p_ack = 1'b0;
      logic [15:0] p_idx = '0;
      logic [31:0] p_dat = '0;
      logic [5:0] p_sel = '0;
      logic [5:0] pat = 6'b101001;
      i_src_rdy = 1'b1;
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (dones > 0 && cyc > done_cyc + 2) break;
         i_src_dat = base + 32'(sent);
         i_dst_ack = stall ? pat[cyc % 6] : 1'b1;
         @(negedge clk);
         if (p_rdy && !p_ack) begin
            chk({name, "_stall_rdy"}, o_dst_rdy, 1);
            chk({name, "_stall_idx"}, {o_dst_idx[0], o_dst_idx[1]}, p_idx);
            chk({name, "_stall_dat"}, o_dst_dat, p_dat);
            chk({name, "_stall_sel"}, {o_dst_sel_beg, o_dst_sel_end}, p_sel);
         end
         if (o_dst_rdy && !i_dst_ack) chk({name, "_src_ack_blocked"}, o_src_ack, 0);
         if (o_dst_rdy && i_dst_ack) begin
            if (got < nbeats) begin
               chk({name, "_idx"}, {o_dst_idx[0], o_dst_idx[1]}, {e_i0[got], e_i1[got]});
               chk({name, "_dat"}, o_dst_dat, base + 32'(got));
               chk({name, "_sel_beg"}, o_dst_sel_beg, e_sb[got]);
               chk({name, "_sel_end"}, o_dst_sel_end, e_se[got]);
               chk({name, "_last"}, o_dst_last, e_se[got][2]);
            end else begin
               chk({name, "_extra_beat"}, got, nbeats);
            end
            if (o_dst_last) last_cyc = cyc;
            got++;
         end
         if (o_done) begin
            dones++;
            done_cyc = cyc;
            chk({name, "_done_timing"}, cyc, last_cyc + 1);
         end
         if (o_src_ack && i_src_rdy) sent++;
         p_rdy = o_dst_rdy;
         p_ack = i_dst_ack;
         p_idx = {o_dst_idx[0], o_dst_idx[1]};
         p_dat = o_dst_dat;
         p_sel = {o_dst_sel_beg, o_dst_sel_end};
         @(posedge clk); #1;
      end
      i_src_rdy = 1'b0;
      i_dst_ack = 1'b0;
      chk({name, "_beat_count"}, got, nbeats);
      chk({name, "_done_count"}, dones, 1);
   endtask

   initial begin
      int got;
      int dones;
      i_rst = 1'b1;
      i_cfg_rdy = 1'b1;
      i_cfg_beg = '0;
      i_cfg_end = '0;
      i_cfg_stride = '0;
      i_src_rdy = 1'b1;
      i_src_dat = '0;
      i_dst_ack = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_dst_rdy", o_dst_rdy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_src_ack", o_src_ack, 0);
      chk("rst_cfg_ack", o_cfg_ack, 0);
      @(posedge clk); #1;
      i_cfg_rdy = 1'b0;
      i_rst = 1'b0;

      // Src beats in IDLE are not acked
      i_src_rdy = 1'b1;
      @(negedge clk);
      chk("idle_src_ack", o_src_ack, 0);
      @(posedge clk); #1;
      i_src_rdy = 1'b0;

      // Case 1: 2x3 box, unit stride, dst always ready
      load_case1();
      cfg(0, 0, 2, 3, 1, 1);
      run_box("c1", 6, 32'h100, 1'b0);

      // Case 2: non-unit strides, non-zero begin
      load_case2();
      cfg(0, 1, 4, 7, 2, 3);
      run_box("c2", 4, 32'h200, 1'b0);

      // Case 3: case 1 with back-pressure
      load_case1();
      cfg(0, 0, 2, 3, 1, 1);
      run_box("c3", 6, 32'h300, 1'b1);

      // Case 4: empty box, then next cfg still accepted
      cfg(0, 5, 2, 5, 1, 1);
      got = 0;
      dones = 0;
      i_src_rdy = 1'b1;
      i_dst_ack = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (o_dst_rdy) got++;
         if (o_done) begin
            dones++;
            chk("c4_done_timing", c, 0);
         end
         chk("c4_src_ack", o_src_ack, 0);
         @(posedge clk); #1;
      end
      i_src_rdy = 1'b0;
      chk("c4_no_beats", got, 0);
      chk("c4_done_count", dones, 1);
      load_case2();
      cfg(0, 1, 4, 7, 2, 3);
      run_box("c4b", 4, 32'h400, 1'b0);

      // Case 5: modulo wrap on inner dim, trivial outer dim
      setb(0, 0, 250, 3'b100, 3'b001);
      setb(1, 0, 252, 3'b001, 3'b001);
      setb(2, 0, 254, 3'b001, 3'b001);
      setb(3, 0, 0,   3'b001, 3'b001);
      setb(4, 0, 2,   3'b001, 3'b100);
      cfg(0, 250, 1, 4, 1, 2);
      run_box("c5", 5, 32'h500, 1'b0);

      // Case 6: reset after 3 beats, then a fresh box
      load_case1();
      cfg(0, 0, 2, 3, 1, 1);
      got = 0;
      i_src_rdy = 1'b1;
      i_dst_ack = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (o_dst_rdy && i_dst_ack) got++;
         @(posedge clk); #1;
         if (got == 3) break;
      end
      chk("c6_pre_beats", got, 3);
      i_rst = 1'b1;
      i_src_rdy = 1'b0;
      @(negedge clk);
      chk("c6_rst_src_ack_hold", i_rst, 1);
      @(posedge clk); #1;
      i_rst = 1'b0;
      @(negedge clk);
      chk("c6_dst_rdy_cleared", o_dst_rdy, 0);
      chk("c6_no_done_at_rst", o_done, 0);
      dones = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (o_done || o_dst_rdy) dones++;
      end
      chk("c6_quiet_after_rst", dones, 0);
      @(posedge clk); #1;
      load_case1();
      cfg(0, 0, 2, 3, 1, 1);
      run_box("c6", 6, 32'h600, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
